// File: rtl/gmii_tx_framer.sv
// Byte-wide GMII transmit framer: preamble/SFD insertion, zero padding, FCS append
// through an external 8-bit CRC32 stage, underrun abort and inter-frame gap.
//
// state | meaning
// IDLE  | waiting for s_valid; preset CRC and emit first preamble byte on start
// PRE   | remaining six 0x55 bytes, then 0xD5
// DATA  | forward upstream bytes into GMII and CRC
// PAD   | zero bytes up to MIN_LEN
// FCS   | four complemented, bit-reversed CRC bytes
// DRAIN | swallow the rest of an underrun frame with tx_en low
// IFG   | enforce the gap with tx_en low
module gmii_tx_framer #(
    parameter int MIN_LEN = 60,
    parameter int IFG_CYC = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic        crc_en,
    output logic        crc_clr,
    output logic [7:0]  crc_din,
    input  logic [31:0] crc_data,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        tx_underrun
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_DATA, S_PAD, S_FCS, S_DRAIN, S_IFG
    } state_t;

    localparam logic [11:0] MIN_LEN_W = 12'(MIN_LEN);
    // IFG reuses the byte counter as a down-counter; IFG_CYC must fit in 11 bits
    localparam logic [10:0] IFG_LOAD  = 11'(IFG_CYC);

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [11:0] cnt_inc;
    logic        tx_en_d, done_d, underrun_d;
    logic [7:0]  txd_d;
    logic [7:0]  crc_byte, fcs_byte;

    assign cnt_inc = {1'b0, cnt_q} + 12'd1;
    assign tx_busy = (state_q != S_IDLE);

    always_comb begin
        crc_byte = 8'h00;
        case (cnt_q[1:0])
            2'd0:    crc_byte = crc_data[31:24];
            2'd1:    crc_byte = crc_data[23:16];
            2'd2:    crc_byte = crc_data[15:8];
            default: crc_byte = crc_data[7:0];
        endcase
        fcs_byte = 8'h00;
        for (int i = 0; i < 8; i++) begin
            fcs_byte[i] = ~crc_byte[7-i];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        s_ready    = 1'b0;
        crc_en     = 1'b0;
        crc_clr    = 1'b0;
        crc_din    = 8'h00;
        tx_en_d    = 1'b0;
        txd_d      = 8'h00;
        done_d     = 1'b0;
        underrun_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (s_valid) begin
                    crc_clr = 1'b1;
                    tx_en_d = 1'b1;
                    txd_d   = 8'h55;
                    cnt_d   = 11'd0;
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                tx_en_d = 1'b1;
                if (cnt_q == 11'd6) begin
                    txd_d   = 8'hD5;
                    cnt_d   = 11'd0;
                    state_d = S_DATA;
                end else begin
                    txd_d = 8'h55;
                    cnt_d = cnt_q + 11'd1;
                end
            end
            S_DATA: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    tx_en_d = 1'b1;
                    txd_d   = s_data;
                    crc_en  = 1'b1;
                    crc_din = s_data;
                    if (s_last) begin
                        if (cnt_inc < MIN_LEN_W) begin
                            cnt_d   = cnt_inc[10:0];
                            state_d = S_PAD;
                        end else begin
                            cnt_d   = 11'd0;
                            state_d = S_FCS;
                        end
                    end else if (cnt_q != 11'h7FF) begin
                        // saturate so oversize frames never wrap back below MIN_LEN
                        cnt_d = cnt_inc[10:0];
                    end
                end else begin
                    underrun_d = 1'b1;
                    state_d    = S_DRAIN;
                end
            end
            S_PAD: begin
                tx_en_d = 1'b1;
                crc_en  = 1'b1;
                if (cnt_inc >= MIN_LEN_W) begin
                    cnt_d   = 11'd0;
                    state_d = S_FCS;
                end else begin
                    cnt_d = cnt_inc[10:0];
                end
            end
            S_FCS: begin
                tx_en_d = 1'b1;
                txd_d   = fcs_byte;
                if (cnt_q[1:0] == 2'd3) begin
                    done_d  = 1'b1;
                    cnt_d   = IFG_LOAD;
                    state_d = S_IFG;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            S_DRAIN: begin
                s_ready = 1'b1;
                if (s_valid && s_last) begin
                    cnt_d   = IFG_LOAD;
                    state_d = S_IFG;
                end
            end
            S_IFG: begin
                if (cnt_q == 11'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 11'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 11'd0;
            gmii_tx_en  <= 1'b0;
            gmii_txd    <= 8'h00;
            tx_done     <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gmii_tx_en  <= tx_en_d;
            gmii_txd    <= txd_d;
            tx_done     <= done_d;
            tx_underrun <= underrun_d;
        end
    end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Scoreboard bench for gmii_tx_framer with a bit-serial CRC32 stage model attached.
module tb_gmii_tx_framer;
    localparam int MIN_LEN = 9;
    localparam int IFG_CYC = 12;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0] d;
        bit         rdy;
        bit         last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_last = 1'b0;
    logic        s_ready, crc_en, crc_clr;
    logic [7:0]  crc_din;
    logic [31:0] crc_data = 32'h0;
    logic        gmii_tx_en, tx_busy, tx_done, tx_underrun;
    logic [7:0]  gmii_txd;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    int   runs[$];
    int   gaps[$];
    int   run_cnt = 0;
    int   low_cnt = 0;
    bit   prev_en = 1'b0;

    gmii_tx_framer #(.MIN_LEN(MIN_LEN), .IFG_CYC(IFG_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .crc_en(crc_en), .crc_clr(crc_clr), .crc_din(crc_din),
        .crc_data(crc_data), .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_underrun(tx_underrun)
    );

    always #4 clk = ~clk;

    // CRC stage: MSB-first register, byte bits folded LSB first; not reset by rst_n
    always @(posedge clk) begin
        logic [31:0] c;
        c = crc_data;
        if (crc_clr) begin
            crc_data <= 32'hFFFFFFFF;
        end else if (crc_en) begin
            for (int b = 0; b < 8; b++) begin
                if (c[31] ^ crc_din[b]) c = {c[30:0], 1'b0} ^ 32'h04C11DB7;
                else                     c = {c[30:0], 1'b0};
            end
            crc_data <= c;
        end
    end

    function automatic logic [31:0] sw_crc(input bq_t d);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (d[i]) begin
            c = c ^ {24'h0, d[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bq_t mk_frame(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    // Monitor: pops the scoreboard on every tx_en cycle; rdy of the next entry is
    // the s_ready expected while that entry is being loaded.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            checks++;
            if (crc_clr && crc_en) begin
                errors++; $display("FAIL crc_excl: crc_clr=%0b crc_en=%0b required not both", crc_clr, crc_en);
            end
            if (gmii_tx_en) begin
                if (!prev_en) begin gaps.push_back(low_cnt); run_cnt = 0; end
                low_cnt = 0;
                run_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL txd_unexpected: got %02h with empty scoreboard", gmii_txd);
                end else begin
                    e = exp_q.pop_front();
                    if (gmii_txd !== e.d) begin
                        errors++; $display("FAIL txd: got %02h required %02h", gmii_txd, e.d);
                    end
                    checks++;
                    if (tx_done !== e.last) begin
                        errors++; $display("FAIL tx_done: got %0b required %0b", tx_done, e.last);
                    end
                    if (exp_q.size() > 0) begin
                        checks++;
                        if (s_ready !== exp_q[0].rdy) begin
                            errors++; $display("FAIL s_ready: got %0b required %0b", s_ready, exp_q[0].rdy);
                        end
                    end
                end
            end else begin
                if (prev_en) runs.push_back(run_cnt);
                low_cnt++;
                checks++;
                if (tx_done !== 1'b0) begin
                    errors++; $display("FAIL tx_done_low: got %0b required 0", tx_done);
                end
                if (!tx_busy) begin
                    checks++;
                    if (s_ready !== 1'b0) begin
                        errors++; $display("FAIL s_ready_idle: got %0b required 0", s_ready);
                    end
                end
            end
            prev_en = gmii_tx_en;
        end else begin
            prev_en = 1'b0;
            low_cnt = 0;
        end
    end

    task automatic push_expected(input bq_t d, input int drop_after, input bit given, input logic [31:0] fcs);
        bq_t p;
        logic [31:0] f;
        exp_t e;
        for (int i = 0; i < 7; i++) begin e = '{8'h55, 1'b0, 1'b0}; exp_q.push_back(e); end
        e = '{8'hD5, 1'b0, 1'b0}; exp_q.push_back(e);
        if (drop_after > 0) begin
            for (int i = 0; i < drop_after; i++) begin e = '{d[i], 1'b1, 1'b0}; exp_q.push_back(e); end
            return;
        end
        p = d;
        foreach (d[i]) begin e = '{d[i], 1'b1, 1'b0}; exp_q.push_back(e); end
        while (p.size() < MIN_LEN) begin
            p.push_back(8'h00);
            e = '{8'h00, 1'b0, 1'b0}; exp_q.push_back(e);
        end
        f = given ? fcs : sw_crc(p);
        for (int k = 0; k < 4; k++) begin
            e = '{f[8*k +: 8], 1'b0, (k == 3)}; exp_q.push_back(e);
        end
    endtask

    task automatic send_frame(input bq_t d, input int drop_after, input bit keep_valid,
                              output int first_acc, output bit en_at1);
        int i = 0;
        int cyc = 0;
        bit acc, dropped = 1'b0, post_drop = 1'b0;
        first_acc = -1;
        en_at1    = 1'b0;
        s_data  = d[0];
        s_last  = (d.size() == 1);
        s_valid = 1'b1;
        while (i < d.size()) begin
            @(posedge clk);
            cyc++;
            acc = s_valid && s_ready;
            #1;
            if (cyc == 1) en_at1 = gmii_tx_en;
            if (post_drop) begin
                post_drop = 1'b0;
                checks++;
                if (tx_underrun !== 1'b0) begin
                    errors++; $display("FAIL underrun_pulse: got %0b required 0", tx_underrun);
                end
            end
            if (cyc > 5000) begin
                checks++; errors++;
                $display("FAIL send_timeout: accepted %0d required %0d", i, d.size());
                break;
            end
            if (acc) begin
                if (first_acc < 0) first_acc = cyc;
                i++;
                if (i == drop_after && !dropped) begin
                    s_valid = 1'b0;
                    s_data  = 8'hA5;
                    s_last  = 1'b1;
                    @(posedge clk); #1;
                    checks++;
                    if (tx_underrun !== 1'b1 || gmii_tx_en !== 1'b0) begin
                        errors++;
                        $display("FAIL underrun: tx_underrun=%0b tx_en=%0b required 1/0", tx_underrun, gmii_tx_en);
                    end
                    dropped   = 1'b1;
                    post_drop = 1'b1;
                    s_valid   = 1'b1;
                end
                if (i < d.size()) begin
                    s_data = d[i];
                    s_last = (i == d.size() - 1);
                end
            end
        end
        if (!keep_valid) s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || tx_busy) && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL wait_timeout: %0d entries left, tx_busy=%0b required 0/0", exp_q.size(), tx_busy);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (gmii_tx_en !== 1'b0 || gmii_txd !== 8'h00 || s_ready !== 1'b0 || crc_en !== 1'b0 ||
            crc_clr !== 1'b0 || crc_din !== 8'h00 || tx_busy !== 1'b0 || tx_done !== 1'b0 ||
            tx_underrun !== 1'b0) begin
            errors++;
            $display("FAIL %s: en=%0b txd=%02h rdy=%0b ce=%0b cc=%0b din=%02h busy=%0b done=%0b ur=%0b required all 0",
                     tag, gmii_tx_en, gmii_txd, s_ready, crc_en, crc_clr, crc_din, tx_busy, tx_done, tx_underrun);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_reset_values("reset_values");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("idle_after_release");
    endtask

    task automatic test_known_vector();
        bq_t d = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        int fa; bit e1;
        runs.delete();
        push_expected(d, 0, 1'b1, 32'hCBF43926);
        send_frame(d, 0, 1'b0, fa, e1);
        wait_done();
        checks++;
        if (fa != 9) begin errors++; $display("FAIL start_latency: first accept at %0d required 9", fa); end
        checks++;
        if (e1 !== 1'b1) begin errors++; $display("FAIL first_preamble: tx_en at t+1 %0b required 1", e1); end
        checks++;
        if (runs.size() != 1 || runs[0] != 21) begin
            errors++; $display("FAIL known_run: runs=%0d first=%0d required 1/21", runs.size(), runs.size() ? runs[0] : -1);
        end
    endtask

    task automatic test_padding();
        int fa; bit e1;
        int lens[2] = '{3, 1};
        foreach (lens[j]) begin
            bq_t d = mk_frame(lens[j]);
            runs.delete();
            push_expected(d, 0, 1'b0, 32'h0);
            send_frame(d, 0, 1'b0, fa, e1);
            wait_done();
            checks++;
            if (fa != 9) begin errors++; $display("FAIL pad_latency: first accept at %0d required 9", fa); end
            checks++;
            if (runs.size() != 1 || runs[0] != 8 + MIN_LEN + 4) begin
                errors++; $display("FAIL pad_run: len=%0d runs=%0d required %0d", lens[j], runs.size() ? runs[0] : -1, 8 + MIN_LEN + 4);
            end
        end
    endtask

    task automatic test_back_to_back();
        bq_t a = mk_frame(64);
        bq_t b = mk_frame(64);
        int fa; bit e1;
        runs.delete(); gaps.delete();
        push_expected(a, 0, 1'b0, 32'h0);
        push_expected(b, 0, 1'b0, 32'h0);
        send_frame(a, 0, 1'b1, fa, e1);
        send_frame(b, 0, 1'b0, fa, e1);
        wait_done();
        checks++;
        if (runs.size() != 2 || runs[0] != 76 || runs[1] != 76) begin
            errors++; $display("FAIL b2b_runs: count=%0d required 2 runs of 76", runs.size());
        end
        checks++;
        if (gaps.size() != 2 || gaps[1] != IFG_CYC + 1) begin
            errors++; $display("FAIL b2b_gap: gap=%0d required %0d", gaps.size() == 2 ? gaps[1] : -1, IFG_CYC + 1);
        end
    endtask

    task automatic test_underrun();
        bq_t a = mk_frame(40);
        bq_t b = mk_frame(30);
        int fa; bit e1;
        runs.delete(); gaps.delete();
        push_expected(a, 20, 1'b0, 32'h0);
        send_frame(a, 20, 1'b0, fa, e1);
        push_expected(b, 0, 1'b0, 32'h0);
        send_frame(b, 0, 1'b0, fa, e1);
        wait_done();
        checks++;
        if (runs.size() != 2 || runs[0] != 28 || runs[1] != 42) begin
            errors++; $display("FAIL underrun_runs: count=%0d first=%0d required 28 then 42", runs.size(), runs.size() ? runs[0] : -1);
        end
        checks++;
        if (gaps.size() != 2 || gaps[1] < IFG_CYC + 1) begin
            errors++; $display("FAIL underrun_gap: gap=%0d required at least %0d", gaps.size() == 2 ? gaps[1] : -1, IFG_CYC + 1);
        end
    endtask

    task automatic test_reset_mid_frame();
        bq_t a = mk_frame(30);
        bq_t b = mk_frame(12);
        int fa; bit e1;
        int n = 0;
        runs.delete();
        push_expected(a, 0, 1'b0, 32'h0);
        send_frame(a, 0, 1'b0, fa, e1);
        while (exp_q.size() > 2 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 200) begin errors++; $display("FAIL fcs_reach: %0d entries left required 2", exp_q.size()); end
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_mid_fcs");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        runs.delete();
        push_expected(b, 0, 1'b0, 32'h0);
        send_frame(b, 0, 1'b0, fa, e1);
        wait_done();
        checks++;
        if (runs.size() != 1 || runs[0] != 24) begin
            errors++; $display("FAIL post_reset_run: count=%0d first=%0d required 1/24", runs.size(), runs.size() ? runs[0] : -1);
        end
    endtask

    initial begin
        test_reset();
        test_known_vector();
        test_padding();
        test_back_to_back();
        test_underrun();
        test_reset_mid_frame();
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
